// File: rtl/sva_result_collector.sv
// Collects SVA checker result strobes over a test window, then streams a 4-word
// report (succ, fail, lazy, first-fail period) and issues a one-cycle verdict.
module sva_result_collector #(
    parameter int unsigned W        = 16,
    parameter int unsigned MAX_FAIL = 1
) (
    input  logic         sys_clk_i,
    input  logic         sys_rst_ni,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic         gclk_posedge_flag_i,
    input  logic         succ_i,
    input  logic         fail_i,
    input  logic         lazy_succ_i,
    input  logic         busy_i,
    output logic         running_o,
    output logic         rpt_valid_o,
    input  logic         rpt_ready_i,
    output logic [1:0]   rpt_idx_o,
    output logic [W-1:0] rpt_data_o,
    output logic         verdict_valid_o,
    output logic         verdict_pass_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StReport} state_e;

    localparam logic [W-1:0] AllOnes  = '1;
    localparam logic [W-1:0] MaxFailW = W'(MAX_FAIL);

    state_e state_q, state_d;

    logic [W-1:0] succ_cnt_q, succ_cnt_d;
    logic [W-1:0] fail_cnt_q, fail_cnt_d;
    logic [W-1:0] lazy_cnt_q, lazy_cnt_d;
    logic [W-1:0] period_cnt_q, period_cnt_d;
    logic [W-1:0] first_fail_q, first_fail_d;
    logic         has_fail_q, has_fail_d;
    logic [1:0]   idx_q, idx_d;
    logic         verdict_valid_q, verdict_valid_d;
    logic         verdict_pass_q, verdict_pass_d;

    logic rpt_fire;
    logic auto_stop;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v, input logic en);
        return (en && (v != AllOnes)) ? v + W'(1) : v;
    endfunction

    assign rpt_fire  = (state_q == StReport) && rpt_ready_i;
    assign auto_stop = (MAX_FAIL != 0) && (fail_cnt_d >= MaxFailW);

    // State register
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start_i) state_d = StRun;
            StRun:    if (stop_i || auto_stop) state_d = StDrain;
            StDrain:  if (!busy_i) state_d = StReport;
            StReport: if (rpt_fire && (idx_q == 2'd3)) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        running_o       = (state_q == StRun) || (state_q == StDrain);
        rpt_valid_o     = (state_q == StReport);
        rpt_idx_o       = idx_q;
        rpt_data_o      = '0;
        verdict_valid_o = verdict_valid_q;
        verdict_pass_o  = verdict_pass_q;
        if (state_q == StReport) begin
            case (idx_q)
                2'd0:    rpt_data_o = succ_cnt_q;
                2'd1:    rpt_data_o = fail_cnt_q;
                2'd2:    rpt_data_o = lazy_cnt_q;
                default: rpt_data_o = first_fail_q;
            endcase
        end
    end

    // Counter and report datapath
    always_comb begin
        succ_cnt_d      = succ_cnt_q;
        fail_cnt_d      = fail_cnt_q;
        lazy_cnt_d      = lazy_cnt_q;
        period_cnt_d    = period_cnt_q;
        first_fail_d    = first_fail_q;
        has_fail_d      = has_fail_q;
        idx_d           = idx_q;
        verdict_valid_d = 1'b0;
        verdict_pass_d  = verdict_pass_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    succ_cnt_d     = '0;
                    fail_cnt_d     = '0;
                    lazy_cnt_d     = '0;
                    period_cnt_d   = '0;
                    first_fail_d   = AllOnes;
                    has_fail_d     = 1'b0;
                    idx_d          = 2'd0;
                    verdict_pass_d = 1'b0;
                end
            end
            StRun, StDrain: begin
                succ_cnt_d = sat_inc(succ_cnt_q, succ_i);
                fail_cnt_d = sat_inc(fail_cnt_q, fail_i);
                lazy_cnt_d = sat_inc(lazy_cnt_q, lazy_succ_i);
                if (state_q == StRun) begin
                    period_cnt_d = sat_inc(period_cnt_q, gclk_posedge_flag_i);
                    // Latch the pre-increment period of the cycle carrying the first fail
                    if (fail_i && !has_fail_q) begin
                        first_fail_d = period_cnt_q;
                        has_fail_d   = 1'b1;
                    end
                end
            end
            StReport: begin
                if (rpt_fire) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        verdict_valid_d = 1'b1;
                        verdict_pass_d  = (fail_cnt_q == '0) && ((|succ_cnt_q) || (|lazy_cnt_q));
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            succ_cnt_q      <= '0;
            fail_cnt_q      <= '0;
            lazy_cnt_q      <= '0;
            period_cnt_q    <= '0;
            first_fail_q    <= AllOnes;
            has_fail_q      <= 1'b0;
            idx_q           <= 2'd0;
            verdict_valid_q <= 1'b0;
            verdict_pass_q  <= 1'b0;
        end else begin
            succ_cnt_q      <= succ_cnt_d;
            fail_cnt_q      <= fail_cnt_d;
            lazy_cnt_q      <= lazy_cnt_d;
            period_cnt_q    <= period_cnt_d;
            first_fail_q    <= first_fail_d;
            has_fail_q      <= has_fail_d;
            idx_q           <= idx_d;
            verdict_valid_q <= verdict_valid_d;
            verdict_pass_q  <= verdict_pass_d;
        end
    end

endmodule

// File: tb/tb_sva_result_collector.sv
// Scoreboard bench: u_a (W=16, MAX_FAIL=1) and u_b (W=4, MAX_FAIL=0) share stimulus,
// gated by sel; per-instance monitors pop expected report words and verdicts.
module tb_sva_result_collector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start = 1'b0, stop = 1'b0, gflag = 1'b0;
    logic succ = 1'b0, fail = 1'b0, lazy = 1'b0;
    logic busy = 1'b0, ready = 1'b1;
    logic sel = 1'b0;

    logic        a_running, a_rpt_valid, a_verdict_valid, a_verdict_pass;
    logic [1:0]  a_rpt_idx;
    logic [15:0] a_rpt_data;
    logic        b_running, b_rpt_valid, b_verdict_valid, b_verdict_pass;
    logic [1:0]  b_rpt_idx;
    logic [3:0]  b_rpt_data;

    sva_result_collector #(.W(16), .MAX_FAIL(1)) u_a (
        .sys_clk_i          (clk),
        .sys_rst_ni         (rst_n),
        .start_i            (start && !sel),
        .stop_i             (stop && !sel),
        .gclk_posedge_flag_i(gflag && !sel),
        .succ_i             (succ && !sel),
        .fail_i             (fail && !sel),
        .lazy_succ_i        (lazy && !sel),
        .busy_i             (busy),
        .running_o          (a_running),
        .rpt_valid_o        (a_rpt_valid),
        .rpt_ready_i        (ready),
        .rpt_idx_o          (a_rpt_idx),
        .rpt_data_o         (a_rpt_data),
        .verdict_valid_o    (a_verdict_valid),
        .verdict_pass_o     (a_verdict_pass)
    );

    sva_result_collector #(.W(4), .MAX_FAIL(0)) u_b (
        .sys_clk_i          (clk),
        .sys_rst_ni         (rst_n),
        .start_i            (start && sel),
        .stop_i             (stop && sel),
        .gclk_posedge_flag_i(gflag && sel),
        .succ_i             (succ && sel),
        .fail_i             (fail && sel),
        .lazy_succ_i        (lazy && sel),
        .busy_i             (busy),
        .running_o          (b_running),
        .rpt_valid_o        (b_rpt_valid),
        .rpt_ready_i        (ready),
        .rpt_idx_o          (b_rpt_idx),
        .rpt_data_o         (b_rpt_data),
        .verdict_valid_o    (b_verdict_valid),
        .verdict_pass_o     (b_verdict_pass)
    );

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] data;
    } word_t;

    word_t wq_a[$];
    word_t wq_b[$];
    bit    vq_a[$];
    bit    vq_b[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic err(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got unexpected event, expected none", name);
    endtask

    task automatic push_report(input bit to_b, input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] w3, input bit pass);
        word_t w;
        logic [15:0] ws[4];
        ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
        for (int i = 0; i < 4; i++) begin
            w.idx  = 2'(i);
            w.data = ws[i];
            if (to_b) wq_b.push_back(w);
            else      wq_a.push_back(w);
        end
        if (to_b) vq_b.push_back(pass);
        else      vq_a.push_back(pass);
    endtask

    // Monitors
    logic        a_hold = 1'b0, b_hold = 1'b0;
    logic [1:0]  a_hidx, b_hidx;
    logic [15:0] a_hdata, b_hdata;

    always @(negedge clk) begin
        word_t w;
        if (a_hold && a_rpt_valid) begin
            chk("a_hold_idx", 32'(a_rpt_idx), 32'(a_hidx));
            chk("a_hold_data", 32'(a_rpt_data), 32'(a_hdata));
        end
        if (a_rpt_valid && ready) begin
            if (wq_a.size() == 0) err("a_extra_word");
            else begin
                w = wq_a.pop_front();
                chk("a_word_idx", 32'(a_rpt_idx), 32'(w.idx));
                chk("a_word_data", 32'(a_rpt_data), 32'(w.data));
            end
        end
        if (a_verdict_valid) begin
            if (vq_a.size() == 0) err("a_extra_verdict");
            else chk("a_verdict_pass", 32'(a_verdict_pass), 32'(vq_a.pop_front()));
        end
        a_hold  <= rst_n && a_rpt_valid && !ready;
        a_hidx  <= a_rpt_idx;
        a_hdata <= a_rpt_data;
    end

    always @(negedge clk) begin
        word_t w;
        if (b_hold && b_rpt_valid) begin
            chk("b_hold_idx", 32'(b_rpt_idx), 32'(b_hidx));
            chk("b_hold_data", 32'(b_rpt_data), 32'(b_hdata));
        end
        if (b_rpt_valid && ready) begin
            if (wq_b.size() == 0) err("b_extra_word");
            else begin
                w = wq_b.pop_front();
                chk("b_word_idx", 32'(b_rpt_idx), 32'(w.idx));
                chk("b_word_data", 32'(b_rpt_data), 32'(w.data));
            end
        end
        if (b_verdict_valid) begin
            if (vq_b.size() == 0) err("b_extra_verdict");
            else chk("b_verdict_pass", 32'(b_verdict_pass), 32'(vq_b.pop_front()));
        end
        b_hold  <= rst_n && b_rpt_valid && !ready;
        b_hidx  <= b_rpt_idx;
        b_hdata <= {12'd0, b_rpt_data};
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic s, input logic f, input logic l, input logic g);
        succ = s; fail = f; lazy = l; gflag = g;
        cyc();
        succ = 1'b0; fail = 1'b0; lazy = 1'b0; gflag = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while ((sel ? (b_running || b_rpt_valid) : (a_running || a_rpt_valid)) && i < 40) begin
            cyc();
            i++;
        end
        if (i >= 40) err(name);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    logic bp_pat[7];

    initial begin
        // Reset values
        #12;
        chk("rst_a_running", 32'(a_running), 0);
        chk("rst_a_rpt_valid", 32'(a_rpt_valid), 0);
        chk("rst_a_rpt_idx", 32'(a_rpt_idx), 0);
        chk("rst_a_rpt_data", 32'(a_rpt_data), 0);
        chk("rst_a_verdict_valid", 32'(a_verdict_valid), 0);
        chk("rst_a_verdict_pass", 32'(a_verdict_pass), 0);
        chk("rst_b_running", 32'(b_running), 0);
        rst_n = 1'b1;
        cyc();

        // Basic pass on u_a
        sel = 1'b0;
        pulse_start();
        chk("basic_running", 32'(a_running), 1);
        for (int i = 0; i < 5; i++) begin
            strobe(1'b0, 1'b0, 1'b0, 1'b1);
            strobe(1'b1, 1'b0, 1'b0, 1'b0);
        end
        push_report(1'b0, 16'd5, 16'd0, 16'd0, 16'hFFFF, 1'b1);
        pulse_stop();
        chk("basic_drain_running", 32'(a_running), 1);
        repeat (5) cyc();
        chk("basic_stop_to_verdict", 32'(a_verdict_valid), 1);
        chk("basic_idle_running", 32'(a_running), 0);
        chk("basic_idle_rpt_valid", 32'(a_rpt_valid), 0);
        cyc();
        chk("basic_verdict_one_cycle", 32'(a_verdict_valid), 0);
        chk("basic_verdict_held", 32'(a_verdict_pass), 1);

        // Auto-stop on first fail; gclk flag in the same cycle must not shift the latch
        pulse_start();
        chk("auto_start_clears_pass", 32'(a_verdict_pass), 0);
        repeat (3) strobe(1'b0, 1'b0, 1'b0, 1'b1);
        push_report(1'b0, 16'd0, 16'd1, 16'd0, 16'd3, 1'b0);
        strobe(1'b0, 1'b1, 1'b0, 1'b1);
        chk("auto_drain_running", 32'(a_running), 1);
        chk("auto_drain_no_rpt", 32'(a_rpt_valid), 0);
        cyc();
        chk("auto_report_started", 32'(a_rpt_valid), 1);
        wait_done("auto_timeout");

        // Backpressure
        pulse_start();
        strobe(1'b1, 1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b1, 1'b1);
        push_report(1'b0, 16'd2, 16'd0, 16'd1, 16'hFFFF, 1'b1);
        ready = 1'b0;
        pulse_stop();
        cyc();
        chk("bp_first_valid", 32'(a_rpt_valid), 1);
        bp_pat[0] = 1'b0; bp_pat[1] = 1'b0; bp_pat[2] = 1'b1; bp_pat[3] = 1'b0;
        bp_pat[4] = 1'b1; bp_pat[5] = 1'b1; bp_pat[6] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ready = bp_pat[i];
            cyc();
        end
        ready = 1'b1;
        chk("bp_verdict_valid", 32'(a_verdict_valid), 1);
        wait_done("bp_timeout");

        // Coincident strobes and DRAIN wait on u_b
        sel = 1'b1;
        pulse_start();
        repeat (2) strobe(1'b0, 1'b0, 1'b0, 1'b1);
        strobe(1'b1, 1'b1, 1'b1, 1'b0);
        chk("coinc_no_autostop", 32'(b_running), 1);
        push_report(1'b1, 16'd1, 16'd1, 16'd2, 16'd2, 1'b0);
        busy = 1'b1;
        pulse_stop();
        for (int i = 0; i < 4; i++) begin
            lazy = (i == 1);
            gflag = (i == 2);
            cyc();
            chk("coinc_drain_hold", 32'(b_rpt_valid), 0);
        end
        lazy = 1'b0;
        gflag = 1'b0;
        busy = 1'b0;
        cyc();
        chk("coinc_report_after_busy", 32'(b_rpt_valid), 1);
        wait_done("coinc_timeout");

        // Saturation at W=4
        pulse_start();
        repeat (20) strobe(1'b1, 1'b0, 1'b0, 1'b0);
        push_report(1'b1, 16'd15, 16'd0, 16'd0, 16'd15, 1'b1);
        pulse_stop();
        wait_done("sat_timeout");

        // Async reset mid-REPORT on u_a
        sel = 1'b0;
        pulse_start();
        repeat (3) strobe(1'b1, 1'b0, 1'b0, 1'b0);
        wq_a.push_back('{idx: 2'd0, data: 16'd3});
        wq_a.push_back('{idx: 2'd1, data: 16'd0});
        pulse_stop();
        repeat (3) cyc();
        chk("mid_rpt_idx_before_reset", 32'(a_rpt_idx), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rpt_valid", 32'(a_rpt_valid), 0);
        chk("mid_rst_running", 32'(a_running), 0);
        chk("mid_rst_rpt_idx", 32'(a_rpt_idx), 0);
        chk("mid_rst_rpt_data", 32'(a_rpt_data), 0);
        #4 rst_n = 1'b1;
        cyc();
        pulse_start();
        repeat (2) strobe(1'b0, 1'b0, 1'b0, 1'b1);
        push_report(1'b0, 16'd0, 16'd0, 16'd0, 16'hFFFF, 1'b0);
        pulse_stop();
        wait_done("fresh_timeout");

        chk("a_words_left", 32'(wq_a.size()), 0);
        chk("b_words_left", 32'(wq_b.size()), 0);
        chk("a_verdicts_left", 32'(vq_a.size()), 0);
        chk("b_verdicts_left", 32'(vq_b.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
